// File: rtl/edge_det_pkg.sv
// Shared constants for the edge detector family.
// Defaults used by neg_edge_det and its synchronizer.
package edge_det_pkg;

  localparam int SYNC_STAGES_DEF = 0;
  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_MAX = 4;

  function automatic logic fall(input logic prev,
                                input logic cur);
    return prev & ~cur;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Cascaded input synchronizer, synchronous active-high reset.
// STAGES=0 passes d straight through to q.
module sync_chain #(
  parameter int STAGES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  if (STAGES == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign q = d;
  end else begin : g_ff
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
      if (rst) begin
        ff <= '0;
      end else begin
        ff[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
          ff[i] <= ff[i-1];
        end
      end
    end

    assign q = ff[STAGES-1];
  end

endmodule

// File: rtl/neg_edge_det.sv
// Falling-edge detector with registered pulse and
// saturating edge counter.
module neg_edge_det
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  output logic             ne,
  output logic [CNT_W-1:0] edge_cnt
);

  logic s;
  logic s_q;
  logic hit;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (sig),
    .q   (s)
  );

  assign hit = fall(s_q, s);

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q      <= 1'b0;
      ne       <= 1'b0;
      edge_cnt <= '0;
    end else begin
      s_q <= s;
      ne  <= hit;
      // Hold at all-ones instead of wrapping.
      if (hit && (edge_cnt != '1)) begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_neg_edge_det.sv
// Scoreboard bench for neg_edge_det: three configurations
// share stimulus and are checked against a history model.
module tb_neg_edge_det;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig = 1'b0;

  logic       ne0, ne2, nec;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cntc;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  neg_edge_det #(.SYNC_STAGES(0), .CNT_W(8)) d0 (
    .clk(clk), .rst(rst), .sig(sig), .ne(ne0), .edge_cnt(cnt0));
  neg_edge_det #(.SYNC_STAGES(2), .CNT_W(8)) d2 (
    .clk(clk), .rst(rst), .sig(sig), .ne(ne2), .edge_cnt(cnt2));
  neg_edge_det #(.SYNC_STAGES(0), .CNT_W(2)) dc (
    .clk(clk), .rst(rst), .sig(sig), .ne(nec), .edge_cnt(cntc));

  typedef struct packed {
    logic [2:0]       ne;
    logic [2:0][31:0] cnt;
  } exp_t;

  exp_t exq[$];

  // Inputs as sampled at each rising edge, index = edge number.
  bit rh[$];
  bit sh[$];

  int lat[3]  = '{0, 2, 0};
  int cmax[3] = '{255, 255, 3};
  int mcnt[3] = '{0, 0, 0};

  function automatic bit r_at(int i);
    if (i < 0) return 1'b1;
    return rh[i];
  endfunction

  function automatic bit s_at(int i);
    if (i < 0) return 1'b0;
    return sh[i];
  endfunction

  // A pulse follows edge k when the two samples taken L edges
  // earlier read 1 then 0 and no reset touched them since.
  function automatic bit ne_exp(int k, int l);
    if (r_at(k)) return 1'b0;
    for (int j = k - 1 - l; j <= k - 1; j++) begin
      if (r_at(j)) return 1'b0;
    end
    return s_at(k - 1 - l) && !s_at(k - l);
  endfunction

  task automatic drive(input bit r, input bit s);
    exp_t e;
    int   k;
    @(negedge clk);
    rst = r;
    sig = s;
    rh.push_back(r);
    sh.push_back(s);
    k = rh.size() - 1;
    for (int d = 0; d < 3; d++) begin
      e.ne[d] = ne_exp(k, lat[d]);
      if (r) mcnt[d] = 0;
      else if (e.ne[d] && mcnt[d] < cmax[d]) mcnt[d]++;
      e.cnt[d] = 32'(mcnt[d]);
    end
    exq.push_back(e);
  endtask

  task automatic run(input bit r, input bit s, input int n);
    for (int i = 0; i < n; i++) drive(r, s);
  endtask

  initial begin : monitor
    exp_t e;
    logic [2:0]       ane;
    logic [2:0][31:0] acnt;
    forever begin
      @(posedge clk);
      #1;
      if (exq.size() > 0) begin
        e = exq.pop_front();
        ane = {nec, ne2, ne0};
        acnt[0] = 32'(cnt0);
        acnt[1] = 32'(cnt2);
        acnt[2] = 32'(cntc);
        for (int d = 0; d < 3; d++) begin
          checks++;
          if (ane[d] !== e.ne[d]) begin
            failures++;
            $display("FAIL ne[dut%0d] t=%0t got=%b exp=%b",
                     d, $time, ane[d], e.ne[d]);
          end
          checks++;
          if (acnt[d] !== e.cnt[d]) begin
            failures++;
            $display("FAIL edge_cnt[dut%0d] t=%0t got=%0d exp=%0d",
                     d, $time, acnt[d], e.cnt[d]);
          end
        end
      end
    end
  end

  initial begin : stim
    int  w;
    bit  s;
    // reset hold, then sig held low
    run(1, 0, 2);
    run(0, 0, 5);
    // single fall
    run(0, 1, 2);
    run(0, 0, 3);
    // rise only
    run(0, 1, 4);
    // alternating 1,0,1,0,1,0 (preceded by the held 1)
    run(0, 0, 1);
    run(0, 1, 1);
    run(0, 0, 1);
    run(0, 1, 1);
    run(0, 0, 4);
    // extra falls to saturate the 2-bit counter
    run(0, 1, 1);
    run(0, 0, 4);
    // reset on the cycle the pulse is high
    run(0, 1, 2);
    run(0, 0, 1);
    run(1, 0, 1);
    run(0, 0, 4);
    // reset asserted while sig toggles
    run(0, 1, 2);
    run(1, 0, 1);
    run(1, 1, 1);
    run(0, 0, 4);
    // randomized runs
    s = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) s = ~s;
      drive($urandom_range(0, 39) == 0, s);
    end
    run(0, 0, 4);
    w = 0;
    while (exq.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    @(posedge clk);
    #2;
    checks++;
    if (exq.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", exq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neg_edge_det.md
NEG_EDGE_DET -- requirements
Module: neg_edge_det

Interface
REQ-001 The parameter SYNC_STAGES SHALL default to 0 and set the number of input synchronizer flops (0..4) in front of edge detection.
REQ-002 The parameter CNT_W SHALL default to 8 and set the width of edge_cnt.
REQ-003 Port clk SHALL be an input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit, reset, synchronous and active-high.
REQ-005 Port sig SHALL be an input, 1 bit, the monitored level signal, possibly asynchronous when SYNC_STAGES>0.
REQ-006 Port ne SHALL be an output, 1 bit, a one-cycle pulse marking a detected high-to-low transition of sig.
REQ-007 Port edge_cnt SHALL be an output, CNT_W bits, a saturating count of detected falling edges since reset.

Function
REQ-008 sig SHALL pass through SYNC_STAGES cascaded flops to form s; with SYNC_STAGES=0, s = sig directly.
REQ-009 A history flop s_q SHALL capture s on every rising clk edge.
REQ-010 ne SHALL be a registered output: on each rising clk edge, ne <= s_q AND NOT s.
- Net effect: ne is high for exactly one clock cycle, starting at the clock edge where s is first sampled low after being sampled high.
REQ-011 With SYNC_STAGES=0, ne SHALL rise at the first rising clk edge at which sig is sampled 0 and the prior edge sampled 1; latency is 1 edge from the sampled transition.
- Each added synchronizer stage adds exactly one cycle of latency.
REQ-012 Rising transitions of sig, and sig held constant at either level, SHALL never assert ne.
REQ-013 Back-to-back falling edges SHALL each produce a separate pulse; the minimum pattern 1,0,1,0 (one sample each) yields ne pulses two cycles apart.
REQ-014 A sig pulse (high or low) shorter than one clock period that is not sampled SHALL produce no ne; no glitch filtering is required.
REQ-015 edge_cnt SHALL increment by 1 on the same clock edge that sets ne to 1.
- It holds at all-ones (saturates) rather than wrapping.
REQ-016 All outputs SHALL be driven from flops; there is no combinational path from sig to ne or edge_cnt.

Reset
REQ-017 While rst=1 at a rising clk edge, the following SHALL be cleared to 0: ne, edge_cnt, all synchronizer flops and s_q.
REQ-018 Because s_q resets to 0, the first sample after reset SHALL NOT produce ne even if sig is 0.
- A falling edge is reported only after sig is sampled 1 at least once following reset.
REQ-019 Asserting rst mid-pulse SHALL force ne to 0 on that edge, with no pulse generated afterward for the interrupted transition.
REQ-020 sig SHALL be ignored while rst is high.

Structure
REQ-021 Shared package edge_det_pkg SHALL hold the default constants SYNC_STAGES_DEF=0 and CNT_W_DEF=8.
REQ-022 The synchronizer SHALL be a separate sub-module sync_chain (parameter STAGES, synchronous active-high reset), passing sig straight through when STAGES=0.
REQ-023 The detector and counter logic SHALL be in neg_edge_det.
REQ-024 A positive-edge companion, if needed, SHALL reuse sync_chain; it is out of scope here.

Verification
REQ-025 The bench SHALL cover each scenario below: the stimulus, then the required response.
- Reset hold: rst=1 for 2 cycles with sig=0, then release with sig held 0 for 5 cycles -> ne=0 and edge_cnt=0 throughout.
- Single fall (SYNC_STAGES=0): sig=1 for 2 cycles, then 0 for 3 cycles -> ne=1 for exactly the one cycle after the first 0 sample; edge_cnt=1.
- Rise only: sig goes 0->1 and stays 1 for 4 cycles -> ne never asserts; edge_cnt unchanged.
- Alternating: sig sampled 1,0,1,0,1,0 -> three single-cycle ne pulses, two cycles apart; edge_cnt=3.
- Sync latency: SYNC_STAGES=2, single fall -> ne pulse appears 2 cycles later than with SYNC_STAGES=0, still one cycle wide.
- Saturation and mid-reset: CNT_W=2 with 5 falls -> edge_cnt sticks at 3; asserting rst on the cycle ne=1 -> ne=0 and edge_cnt=0 on the next edge.
